// File: rtl/red_pitaya_pwm_dac_pkg.sv
// Shared constants and config-word layout for the dithered slow-DAC PWM channel.
package red_pitaya_pwm_pkg;

  localparam int CCW        = 24;
  localparam int DUTY_W     = 8;
  localparam int SEQ_W      = 16;
  localparam int IDX_W      = 4;
  localparam int PWM_PERIOD = 256;

  localparam int DUTY_MSB = 23;
  localparam int DUTY_LSB = 16;
  localparam int SEQ_MSB  = 15;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [SEQ_W-1:0]  seq;
  } pwm_cfg_t;

endpackage

// File: rtl/red_pitaya_pwm_dac_if.sv
// Config word in, PWM stream and period/frame strobes out.
interface red_pitaya_pwm_dac_if;
  import red_pitaya_pwm_pkg::*;

  logic [CCW-1:0] cfg_i;
  logic           pwm_o;
  logic           period_o;
  logic           frame_o;

  modport master (output cfg_i, input pwm_o, period_o, frame_o);
  modport slave  (input cfg_i, output pwm_o, period_o, frame_o);
endinterface

// File: rtl/red_pitaya_pwm_dac_timebase.sv
// Free-running PWM counter plus dither period index; flags the last cycle of period/frame.
module red_pitaya_pwm_timebase
  import red_pitaya_pwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [DUTY_W-1:0] cnt,
  output logic [IDX_W-1:0]  idx,
  output logic              period_last,
  output logic              frame_last
);

  assign period_last = &cnt;
  assign frame_last  = period_last && (&idx);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (period_last) idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Dithered PWM slow-DAC channel: 8-bit duty per 256-cycle period, plus a 16-period
// dither pattern when RED_PITAYA_PWM_DITHER_EN is defined (8-bit duty only otherwise).
module red_pitaya_pwm_dac
  import red_pitaya_pwm_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  red_pitaya_pwm_dac_if.slave bus
);

  logic [DUTY_W-1:0] cnt;
  logic [IDX_W-1:0]  idx;
  logic              period_last;
  logic              frame_last;
  logic [DUTY_W:0]   thr;

  red_pitaya_pwm_timebase u_tb (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .cnt         (cnt),
    .idx         (idx),
    .period_last (period_last),
    .frame_last  (frame_last)
  );

  // Shadow only updates at the frame boundary so a frame's dither average stays intact.
`ifdef RED_PITAYA_PWM_DITHER_EN
  pwm_cfg_t cfg_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         cfg_r <= '0;
    else if (frame_last) cfg_r <= pwm_cfg_t'(bus.cfg_i);
  end

  // 9 bits: duty 0xFF plus a set dither bit reaches 256, i.e. high for the whole period.
  assign thr = {1'b0, cfg_r.duty} + {{DUTY_W{1'b0}}, cfg_r.seq[idx]};
`else
  logic [DUTY_W-1:0] duty_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)         duty_r <= '0;
    else if (frame_last) duty_r <= bus.cfg_i[DUTY_MSB:DUTY_LSB];
  end

  assign thr = {1'b0, duty_r};
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.pwm_o    <= 1'b0;
      bus.period_o <= 1'b0;
      bus.frame_o  <= 1'b0;
    end else begin
      bus.pwm_o    <= ({1'b0, cnt} < thr);
      bus.period_o <= (cnt == '0);
      bus.frame_o  <= (cnt == '0) && (idx == '0);
    end
  end

endmodule
